// File: rtl/memory_bus_router.sv
// memory_bus_router: routes one CPU byte-access port to NUM_REGIONS regions
// selected by address bits, with a request/busy handshake, minimum wait,
// per-access timeout and sticky bus-error flag.
// Optional feature macro: MEMORY_BUS_ROUTER_WRITE_PROTECT_EN (read-only regions
// from RO_MASK); when undefined every region is writable.
module memory_bus_router #(
    parameter int unsigned              ADDR_WIDTH  = 24,
    parameter int unsigned              DATA_WIDTH  = 8,
    parameter int unsigned              NUM_REGIONS = 4,
    parameter int unsigned              SEL_LSB     = 14,
    parameter int unsigned              MIN_WAIT    = 0,
    parameter int unsigned              TIMEOUT     = 255,
    parameter logic [NUM_REGIONS-1:0]   RO_MASK     = 4'b0010
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             cpu_address,
    input  logic [DATA_WIDTH-1:0]             cpu_data_in,
    output logic [DATA_WIDTH-1:0]             cpu_data_out,
    input  logic                              cpu_enable,
    input  logic                              cpu_write_enable,
    output logic                              cpu_halt,
    output logic [NUM_REGIONS-1:0]            region_enable,
    output logic [NUM_REGIONS-1:0]            region_write_enable,
    output logic [ADDR_WIDTH-1:0]             region_address,
    output logic [DATA_WIDTH-1:0]             region_data_in,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_data_out,
    input  logic [NUM_REGIONS-1:0]            region_busy,
    input  logic                              error_clear,
    output logic                              error
);

    localparam int unsigned R       = $clog2(NUM_REGIONS);
    localparam logic [3:0]  MW      = 4'(MIN_WAIT);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

`ifdef MEMORY_BUS_ROUTER_WRITE_PROTECT_EN
    localparam logic [NUM_REGIONS-1:0] RO_ACTIVE = RO_MASK;
`else
    // Write protection compiled out: no region is treated as read-only.
    localparam logic [NUM_REGIONS-1:0] RO_ACTIVE = RO_MASK & '0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state, state_next;
    logic [R-1:0]           sel_dec, sel_q;
    logic                   we_q;
    logic [3:0]             wait_cnt;
    logic [15:0]            to_cnt;
    logic                   busy_sel;
    logic [DATA_WIDTH-1:0]  rdata_sel;
    logic                   wp;
    logic                   complete;
    logic                   timeout;
    logic                   err_set;

    // Region decode: addresses beyond the select field go to the far region.
    always_comb begin
        if ((cpu_address >> (SEL_LSB + R)) == '0)
            sel_dec = cpu_address[SEL_LSB +: R];
        else
            sel_dec = R'(NUM_REGIONS - 1);
    end

    // Selected-region status and completion/timeout conditions.
    always_comb begin
        busy_sel  = region_busy[sel_q];
        rdata_sel = region_data_out[sel_q*DATA_WIDTH +: DATA_WIDTH];
        wp        = we_q & RO_ACTIVE[sel_q];
        complete  = (wait_cnt == MW) && (wp || !busy_sel);
        timeout   = (to_cnt == TO_LAST);
        err_set   = (state == ACCESS) && ((complete && wp) || (!complete && timeout));
    end

    // State register; reset forces IDLE so strobes drop immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_next          = state;
        cpu_halt            = 1'b0;
        region_enable       = '0;
        region_write_enable = '0;
        case (state)
            IDLE: begin
                cpu_halt = cpu_enable;
                if (cpu_enable) state_next = ACCESS;
            end
            ACCESS: begin
                cpu_halt                   = 1'b1;
                region_enable[sel_q]       = 1'b1;
                region_write_enable[sel_q] = we_q & ~wp;
                if (complete || timeout) state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, counters and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            region_address <= '0;
            region_data_in <= '0;
            cpu_data_out   <= '0;
            we_q           <= 1'b0;
            sel_q          <= '0;
            wait_cnt       <= '0;
            to_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_enable) begin
                        region_address <= cpu_address;
                        region_data_in <= cpu_data_in;
                        we_q           <= cpu_write_enable;
                        sel_q          <= sel_dec;
                        wait_cnt       <= '0;
                        to_cnt         <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != MW) wait_cnt <= wait_cnt + 4'd1;
                    if (to_cnt != '1)   to_cnt   <= to_cnt + 16'd1;
                    // Completion takes priority over a coincident timeout.
                    if (complete) begin
                        if (!we_q) cpu_data_out <= rdata_sel;
                    end else if (timeout) begin
                        cpu_data_out <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky bus error: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           error <= 1'b0;
        else if (err_set)     error <= 1'b1;
        else if (error_clear) error <= 1'b0;
    end

endmodule

// File: doc/memory_bus_router.md
Name: memory_bus_router

Overview:
Parametrised successor to the fixed four-bank CPU memory decoder. It routes one CPU byte-access port to NUM_REGIONS memory/peripheral regions selected by address bits. Accesses use a registered request/busy handshake with a programmable minimum wait, a per-access timeout and a sticky bus-error flag. It sits between the CPU core and the RAM, ROM, peripherals and SPI flash blocks. Any slow region stalls the CPU through cpu_halt.

Parameters:
ADDR_WIDTH, 24, CPU address width.
DATA_WIDTH, 8, data width.
NUM_REGIONS, 4, number of regions; power of two, 2..16.
SEL_LSB, 14, lowest address bit of the region-select field.
MIN_WAIT, 0, minimum cycles in ACCESS before completion is allowed; 0..15.
TIMEOUT, 255, cycles in ACCESS before forced abort; must be greater than MIN_WAIT, at most 2^16-1.
RO_MASK, 4'b0010, bit i set means region i is read-only; used only with the optional feature.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
cpu_address  in  ADDR_WIDTH  access address.
cpu_data_in  in  DATA_WIDTH  write data.
cpu_data_out  out  DATA_WIDTH  registered read data.
cpu_enable  in  1  access request.
cpu_write_enable  in  1  1 = write, 0 = read; sampled with cpu_enable.
cpu_halt  out  1  CPU stall.
region_enable  out  NUM_REGIONS  one-hot region select.
region_write_enable  out  NUM_REGIONS  one-hot write strobe.
region_address  out  ADDR_WIDTH  latched address, shared by all regions.
region_data_in  out  DATA_WIDTH  latched write data, shared by all regions.
region_data_out  in  NUM_REGIONS*DATA_WIDTH  read data; region i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
region_busy  in  NUM_REGIONS  region not ready.
error_clear  in  1  clears the error flag.
error  out  1  sticky bus error.

Behaviour:
- Region decode:
  - R = log2(NUM_REGIONS).
  - If address bits above SEL_LSB+R-1 are all zero, sel = address[SEL_LSB+R-1:SEL_LSB].
  - Otherwise sel = NUM_REGIONS-1 (the far/flash region).
- Reset (while reset is low):
  - state = IDLE; cpu_data_out, region_address, region_data_in = 0.
  - region_enable, region_write_enable, error = 0; both counters = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On cpu_enable=1: latch address, data, write bit and sel; clear wait_cnt and to_cnt; go to ACCESS.
  - cpu_halt = cpu_enable (combinational), so the CPU stalls in the request cycle.
- ACCESS:
  - region_enable[sel] = 1; region_write_enable[sel] = latched write; cpu_halt = 1.
  - wait_cnt saturates at MIN_WAIT; to_cnt increments each cycle.
  - Completion: wait_cnt == MIN_WAIT and region_busy[sel] == 0.
    - On a read, cpu_data_out <= selected slice. On a write, cpu_data_out holds its value.
    - Go to DONE.
  - Timeout: to_cnt reaches TIMEOUT with no completion.
    - cpu_data_out <= all ones; error <= 1; go to DONE.
  - If completion and timeout fall in the same cycle, completion wins.
  - Minimum access: MIN_WAIT=0 with busy low gives exactly 1 ACCESS cycle, so the CPU sees 2 halt cycles.
- DONE:
  - One cycle; all region strobes low; cpu_halt = 0; cpu_data_out valid. Go to IDLE.
  - cpu_enable is ignored in DONE. If it is still high in the following IDLE cycle, a new access starts.
- Inputs during ACCESS: changes to cpu_address, cpu_data_in or cpu_enable are ignored; latched values are used.
- Error flag:
  - error_clear=1 clears error in the next cycle.
  - If clear and set occur in the same cycle, set wins.
- Reset mid-access: asserting reset in any state forces IDLE immediately. Strobes drop asynchronously and no write completes.
- All counter arithmetic is unsigned; counters never wrap.

Optional Feature:
MEMORY_BUS_ROUTER_WRITE_PROTECT_EN
- Defined: a write to a region with its RO_MASK bit set still goes through ACCESS, but region_write_enable stays 0 for the whole access (region_enable still asserts). It completes after MIN_WAIT regardless of busy, sets error, and leaves cpu_data_out unchanged.
- Not defined: RO_MASK is ignored and all regions are writable.

Test Plan:
- Read, region 0 at 0x000010, MIN_WAIT=0, busy=0, region 0 data 0x5A -> region_enable=4'b0001 for 1 cycle; cpu_halt high 2 cycles; cpu_data_out=0x5A in DONE; error=0.
- Write 0xC3 to 0x008004 (region 2) -> region_write_enable=4'b0100 for 1 cycle; region_address=0x008004; region_data_in=0xC3.
- Read 0x010000 (upper bits nonzero), busy[3] high 20 cycles -> region 3 selected; 21 ACCESS cycles; halt released after busy falls.
- TIMEOUT=8, busy[1] held high -> DONE after 8 ACCESS cycles; cpu_data_out=0xFF; error=1. error_clear together with a new timeout -> error stays 1.
- reset low during ACCESS on a write -> strobes drop at once; next access after release behaves normally.
- WRITE_PROTECT_EN, RO_MASK=4'b0010, write to 0x004000 -> region_write_enable stays 0; error=1; halt released.
